// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC and the SRAM address, and drives the IF/ID register.
// It applies ID redirects, hazard stalls and wrong-path squashes.
//
// state | meaning
// BOOT  | first cycle after reset; PC held, redirects ignored, IF/ID gets bubbles
// RUN   | normal fetch; stays here until the next reset
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IM_ADDR_W = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PC_write,
  input  logic                 IF_ID_write,
  input  logic                 branch,
  input  logic [31:0]          branch_target,
  input  logic                 jalr_taken,
  input  logic [31:0]          jump_target,
  input  logic [31:0]          IM_DO,
  output logic [IM_ADDR_W-1:0] IM_addr,
  output logic                 IM_OE,
  output logic [31:0]          pc_f,
  output logic [31:0]          IF_ID_pc,
  output logic [31:0]          IF_ID_inst,
  output logic                 IF_flush_out,
  output logic                 IF_ID_write_delay,
  output logic                 misalign_err,
  output logic [31:0]          fetch_cnt,
  output logic [31:0]          stall_cnt
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  fetch_state_t state, state_next;

  logic        fetch_valid;
  logic        accept;
  logic        squash;
  logic [31:0] target_sel;
  logic [31:0] pc_next;

  assign fetch_valid = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == BOOT) state_next = RUN;
  end

  // The stall wins: a redirect is only taken when both PC and IF/ID may advance.
  assign accept     = fetch_valid & PC_write & IF_ID_write & (branch | jalr_taken);
  assign target_sel = jalr_taken ? jump_target : branch_target;
  assign squash     = IF_ID_write & (accept | ~fetch_valid);

  always_comb begin
    pc_next = pc_f;
    if (fetch_valid) begin
      if (!PC_write)   pc_next = pc_f;
      else if (accept) pc_next = {target_sel[31:2], 2'b00};
      else             pc_next = pc_f + 32'd4;
    end
  end

  // The SRAM captures pc_next at the edge, so its data corresponds to pc_f in the following cycle.
  assign IM_addr = pc_next[IM_ADDR_W+1:2];
  assign IM_OE   = ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_f <= RESET_PC;
    else     pc_f <= pc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IF_ID_pc   <= 32'h0;
      IF_ID_inst <= 32'h0;
    end else if (IF_ID_write) begin
      if (squash) begin
        IF_ID_pc   <= 32'h0;
        IF_ID_inst <= 32'h0;
      end else begin
        IF_ID_pc   <= pc_f;
        IF_ID_inst <= IM_DO;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IF_flush_out      <= 1'b0;
      IF_ID_write_delay <= 1'b1;
      misalign_err      <= 1'b0;
    end else begin
      IF_flush_out      <= accept;
      IF_ID_write_delay <= IF_ID_write;
      if (accept && (target_sel[1:0] != 2'b00)) misalign_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (IF_ID_write && !squash) fetch_cnt <= fetch_cnt + 32'd1;
      if (fetch_valid && !PC_write) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; a registered SRAM model returns {word_addr,2'b00}|1.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PC_write = 1'b1;
  logic        IF_ID_write = 1'b1;
  logic        branch = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jalr_taken = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic [31:0] IM_DO = 32'h0;
  logic [13:0] IM_addr;
  logic        IM_OE;
  logic [31:0] pc_f;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_inst;
  logic        IF_flush_out;
  logic        IF_ID_write_delay;
  logic        misalign_err;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad = 0;

  if_fetch_stage #(.RESET_PC(32'h0), .IM_ADDR_W(14)) dut (
    .clk(clk), .rst(rst), .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .branch(branch), .branch_target(branch_target), .jalr_taken(jalr_taken),
    .jump_target(jump_target), .IM_DO(IM_DO), .IM_addr(IM_addr), .IM_OE(IM_OE),
    .pc_f(pc_f), .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst),
    .IF_flush_out(IF_flush_out), .IF_ID_write_delay(IF_ID_write_delay),
    .misalign_err(misalign_err), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (IM_OE) IM_DO <= {16'h0, IM_addr, 2'b00} | 32'h1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (pc_f !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=%h", pc_f, 32'h0); end
    total++; if (IF_ID_inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h exp=%h", IF_ID_inst, 32'h0); end
    total++; if (IF_ID_write_delay !== 1'b1) begin bad++; $display("FAIL rst_wdelay got=%b exp=1", IF_ID_write_delay); end
    total++; if (IM_OE !== 1'b0) begin bad++; $display("FAIL rst_oe got=%b exp=0", IM_OE); end
    total++; if (IM_addr !== 14'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", IM_addr); end
    rst = 1'b0;
    tick(); // edge 1: BOOT
    total++; if (IF_ID_inst !== 32'h0 || pc_f !== 32'h0) begin bad++; $display("FAIL boot_edge1 inst=%h pc_f=%h exp 0/0", IF_ID_inst, pc_f); end
    tick(); // edge 2
    total++; if (IF_ID_pc !== 32'h0 || IF_ID_inst !== 32'h1) begin bad++; $display("FAIL edge2 pc=%h inst=%h exp 0/1", IF_ID_pc, IF_ID_inst); end
    total++; if (pc_f !== 32'h4) begin bad++; $display("FAIL edge2_pcf got=%h exp=4", pc_f); end
    tick(); // edge 3
    total++; if (IF_ID_pc !== 32'h4 || IF_ID_inst !== 32'h5) begin bad++; $display("FAIL edge3 pc=%h inst=%h exp 4/5", IF_ID_pc, IF_ID_inst); end
    total++; if (pc_f !== 32'h8) begin bad++; $display("FAIL edge3_pcf got=%h exp=8", pc_f); end
    total++; if (fetch_cnt !== 32'd2) begin bad++; $display("FAIL edge3_fcnt got=%0d exp=2", fetch_cnt); end
  endtask

  task automatic test_stall();
    tick(); tick(); // pc_f 0xC then 0x10
    total++; if (pc_f !== 32'h10 || IF_ID_pc !== 32'hC) begin bad++; $display("FAIL pre_stall pc_f=%h ifid=%h exp 10/c", pc_f, IF_ID_pc); end
    PC_write = 1'b0; IF_ID_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pc_f !== 32'h10 || IF_ID_pc !== 32'hC || IF_ID_inst !== 32'hD) begin bad++; $display("FAIL stall_hold%0d pc_f=%h pc=%h inst=%h exp 10/c/d", i, pc_f, IF_ID_pc, IF_ID_inst); end
      total++; if (IF_ID_write_delay !== 1'b0) begin bad++; $display("FAIL stall_wdelay%0d got=%b exp=0", i, IF_ID_write_delay); end
    end
    total++; if (stall_cnt !== 32'd3) begin bad++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
    PC_write = 1'b1; IF_ID_write = 1'b1;
    tick();
    total++; if (pc_f !== 32'h14 || IF_ID_pc !== 32'h10 || IF_ID_inst !== 32'h11) begin bad++; $display("FAIL resume pc_f=%h pc=%h inst=%h exp 14/10/11", pc_f, IF_ID_pc, IF_ID_inst); end
    total++; if (IF_ID_write_delay !== 1'b1 || fetch_cnt !== 32'd5 || stall_cnt !== 32'd3) begin bad++; $display("FAIL resume_cnt wd=%b fcnt=%0d scnt=%0d exp 1/5/3", IF_ID_write_delay, fetch_cnt, stall_cnt); end
  endtask

  task automatic test_branch();
    branch = 1'b1; branch_target = 32'h100;
    tick();
    branch = 1'b0;
    total++; if (pc_f !== 32'h100 || IF_ID_inst !== 32'h0 || IF_ID_pc !== 32'h0) begin bad++; $display("FAIL br_edge pc_f=%h inst=%h pc=%h exp 100/0/0", pc_f, IF_ID_inst, IF_ID_pc); end
    total++; if (IF_flush_out !== 1'b1) begin bad++; $display("FAIL br_flush got=%b exp=1", IF_flush_out); end
    tick();
    total++; if (IF_ID_pc !== 32'h100 || IF_ID_inst !== 32'h101 || pc_f !== 32'h104) begin bad++; $display("FAIL br_land pc=%h inst=%h pc_f=%h exp 100/101/104", IF_ID_pc, IF_ID_inst, pc_f); end
    total++; if (IF_flush_out !== 1'b0 || fetch_cnt !== 32'd6) begin bad++; $display("FAIL br_after flush=%b fcnt=%0d exp 0/6", IF_flush_out, fetch_cnt); end
  endtask

  task automatic test_jalr_priority();
    branch = 1'b1; jalr_taken = 1'b1; jump_target = 32'h203; branch_target = 32'h300;
    tick();
    branch = 1'b0; jalr_taken = 1'b0;
    total++; if (pc_f !== 32'h200) begin bad++; $display("FAIL jalr_pc got=%h exp=200", pc_f); end
    total++; if (misalign_err !== 1'b1 || IF_flush_out !== 1'b1) begin bad++; $display("FAIL jalr_flags mis=%b flush=%b exp 1/1", misalign_err, IF_flush_out); end
    tick();
    total++; if (misalign_err !== 1'b1 || IF_ID_pc !== 32'h200 || IF_ID_inst !== 32'h201) begin bad++; $display("FAIL jalr_after mis=%b pc=%h inst=%h exp 1/200/201", misalign_err, IF_ID_pc, IF_ID_inst); end
  endtask

  task automatic test_redirect_stalled();
    branch = 1'b1; branch_target = 32'h400; PC_write = 1'b0;
    tick();
    total++; if (pc_f !== 32'h204 || IF_flush_out !== 1'b0) begin bad++; $display("FAIL br_stall pc_f=%h flush=%b exp 204/0", pc_f, IF_flush_out); end
    total++; if (stall_cnt !== 32'd4 || fetch_cnt !== 32'd8) begin bad++; $display("FAIL br_stall_cnt scnt=%0d fcnt=%0d exp 4/8", stall_cnt, fetch_cnt); end
    PC_write = 1'b1; IF_ID_write = 1'b0;
    tick();
    total++; if (pc_f !== 32'h208 || IF_flush_out !== 1'b0) begin bad++; $display("FAIL br_ifid_stall pc_f=%h flush=%b exp 208/0", pc_f, IF_flush_out); end
    branch = 1'b0; IF_ID_write = 1'b1;
  endtask

  task automatic test_wrap_and_midreset();
    branch = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch = 1'b0;
    total++; if (pc_f !== 32'hFFFF_FFFC || misalign_err !== 1'b1) begin bad++; $display("FAIL wrap_pre pc_f=%h mis=%b exp fffffffc/1", pc_f, misalign_err); end
    tick();
    total++; if (pc_f !== 32'h0 || IF_ID_pc !== 32'hFFFF_FFFC || IF_ID_inst !== 32'h0000_FFFD) begin bad++; $display("FAIL wrap pc_f=%h pc=%h inst=%h exp 0/fffffffc/fffd", pc_f, IF_ID_pc, IF_ID_inst); end
    branch = 1'b1; branch_target = 32'h40;
    tick();
    branch = 1'b0;
    total++; if (pc_f !== 32'h40) begin bad++; $display("FAIL mid_pre pc_f=%h exp=40", pc_f); end
    rst = 1'b1;
    #2;
    total++; if (pc_f !== 32'h0 || IF_ID_pc !== 32'h0 || IF_ID_inst !== 32'h0 || IF_flush_out !== 1'b0) begin bad++; $display("FAIL mid_rst_regs pc_f=%h pc=%h inst=%h flush=%b exp all 0", pc_f, IF_ID_pc, IF_ID_inst, IF_flush_out); end
    total++; if (misalign_err !== 1'b0 || fetch_cnt !== 32'h0 || stall_cnt !== 32'h0 || IF_ID_write_delay !== 1'b1 || IM_OE !== 1'b0) begin bad++; $display("FAIL mid_rst_flags mis=%b fcnt=%0d scnt=%0d wd=%b oe=%b exp 0/0/0/1/0", misalign_err, fetch_cnt, stall_cnt, IF_ID_write_delay, IM_OE); end
    tick();
    rst = 1'b0; branch = 1'b1; branch_target = 32'h80;
    tick(); // edge 1: BOOT ignores the redirect
    branch = 1'b0;
    total++; if (pc_f !== 32'h0 || IF_flush_out !== 1'b0 || IF_ID_inst !== 32'h0) begin bad++; $display("FAIL boot_ignore pc_f=%h flush=%b inst=%h exp 0/0/0", pc_f, IF_flush_out, IF_ID_inst); end
    tick(); // edge 2
    total++; if (IF_ID_pc !== 32'h0 || IF_ID_inst !== 32'h1 || pc_f !== 32'h4) begin bad++; $display("FAIL restart pc=%h inst=%h pc_f=%h exp 0/1/4", IF_ID_pc, IF_ID_inst, pc_f); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_jalr_priority();
    test_redirect_stalled();
    test_wrap_and_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the ID stage.
- Owns the fetch PC and the synchronous instruction-SRAM address. It drives the IF/ID pipeline register (instruction and PC) that the ID stage consumes.
- Applies redirects that ID resolves (taken branch/JAL, JALR), hazard-unit stalls, and squashing of wrong-path fetches.
- Provides the IF_flush_out and IF_ID_write_delay indications consumed by ID.

Parameters:
RESET_PC, 32'h0000_0000, byte address of the first fetched instruction.
IM_ADDR_W, 14, word-address width of the instruction SRAM.

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  asynchronous, active-high reset
PC_write  in  1  hazard unit; 0 = hold the PC (stall)
IF_ID_write  in  1  hazard unit; 0 = hold the IF/ID register
branch  in  1  ID: conditional branch taken, or JAL
branch_target  in  32  ID: target for branch/JAL
jalr_taken  in  1  ID: JALR in ID
jump_target  in  32  ID: JALR target
IM_DO  in  32  instruction SRAM read data (valid in the cycle after address capture)
IM_addr  out  IM_ADDR_W  SRAM word address = pc_next[IM_ADDR_W+1:2]
IM_OE  out  1  SRAM read enable; constant 1 when not in reset
pc_f  out  32  address whose instruction is on IM_DO this cycle
IF_ID_pc  out  32  IF/ID register: PC
IF_ID_inst  out  32  IF/ID register: instruction; 32'h0 = bubble
IF_flush_out  out  1  1 for the cycle after an accepted redirect
IF_ID_write_delay  out  1  IF_ID_write registered one cycle
misalign_err  out  1  sticky: a redirect target had bits[1:0] != 0
fetch_cnt  out  32  non-bubble instructions written into IF/ID
stall_cnt  out  32  cycles with PC_write=0 while fetch_valid=1

Behaviour:
- Reset values (async, while rst=1):
  - pc_f=RESET_PC; fetch_valid=0; IF_ID_pc=0; IF_ID_inst=0.
  - IF_flush_out=0; IF_ID_write_delay=1; misalign_err=0; fetch_cnt=0; stall_cnt=0.
  - IM_addr=RESET_PC word address; IM_OE=0.
- State: fetch_valid is a 2-state FSM.
  - BOOT (fetch_valid=0): pc_next=pc_f; all redirects ignored; IF/ID written with bubble (inst 0, pc 0). Moves to RUN at the first edge after reset release.
  - RUN (fetch_valid=1): remains in RUN until the next reset.
- Redirect acceptance: accept = fetch_valid & PC_write & IF_ID_write & (branch | jalr_taken). A redirect with PC_write=0 or IF_ID_write=0 is ignored, because the stall wins.
- pc_next in RUN, first matching rule applies:
  - !PC_write -> pc_f (the SRAM re-reads the same word, so IM_DO is stable).
  - accept & jalr_taken -> {jump_target[31:2],2'b00}.
  - accept & branch -> {branch_target[31:2],2'b00}.
  - otherwise -> pc_f+4, mod 2^32 (wraps 32'hFFFF_FFFC -> 0).
- jalr_taken has priority over branch when both are set.
- pc_f <= pc_next every edge.
- IF/ID register on each edge:
  - IF_ID_write=0: hold both fields.
  - IF_ID_write=1 & (accept | !fetch_valid): IF_ID_inst<=0, IF_ID_pc<=0. This squashes the wrong-path instruction on the same edge.
  - otherwise: IF_ID_inst<=IM_DO, IF_ID_pc<=pc_f.
- Pipeline latency: an address is presented at edge N and its instruction lands in IF/ID at edge N+1. After reset release, RESET_PC reaches IF/ID at the 2nd edge.
- IF_flush_out <= accept (exactly one cycle high). Back-to-back accepts cannot occur because ID holds a bubble; if they do occur, IF_flush_out stays high.
- IF_ID_write_delay <= IF_ID_write.
- misalign_err is set at an accepted redirect whose selected target has [1:0] != 0. Only reset clears it.
- Counters: fetch_cnt increments when a non-squashed IM_DO is written into IF/ID. stall_cnt increments when fetch_valid & !PC_write. Both wrap at 2^32.
- Reset mid-operation clears everything asynchronously; fetch restarts in BOOT at RESET_PC.

Test Plan:
- Reset, release, IM returns inst=addr|1 -> edge2: IF_ID_pc=0, IF_ID_inst=32'h1; edge3: IF_ID_pc=4; pc_f increments by 4 per edge; fetch_cnt=2 after edge3.
- PC_write=0, IF_ID_write=0 for 3 cycles at pc_f=0x10 -> pc_f, IF_ID_pc and IF_ID_inst frozen; IF_ID_write_delay=0 one cycle later; stall_cnt=3; fetch resumes at 0x14.
- branch=1, branch_target=0x100 in RUN -> next edge: pc_f=0x100, IF_ID_inst=0, IF_flush_out=1 for one cycle; edge after that: IF_ID_pc=0x100.
- branch=1 and jalr_taken=1 with jump_target=0x203, branch_target=0x300 -> pc_f=0x200, misalign_err=1 and stays 1.
- branch=1 with PC_write=0 -> redirect ignored, pc_f held, IF_flush_out=0.
- rst asserted mid-stream at pc_f=0x40 -> all outputs at reset values immediately; after release, RESET_PC reaches IF/ID at edge 2.
